ex_wb: RTL and testbench
========================

EX_WB -- requirements
Module: ex_wb

Interface
REQ-001: clk  input  1  core clock; all state updates on rising edge.
REQ-002: resetb  input  1  asynchronous, active-low reset.
REQ-003: id_valid  input  1  decoded instruction present from IF_ID.
REQ-004: id_ready  output  1  block accepts the instruction this cycle; transfer = id_valid & id_ready.
REQ-005: id_pc  input  32  PC of the presented instruction.
REQ-006: id_op  input  5  operation code, enumerated in ex_wb_pkg (ADD..AND, SLT/SLTU, shifts, LUI, AUIPC, BEQ..BGEU, JAL, JALR, LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-007: id_rs1_data, id_rs2_data  input  32 each  source operands.
REQ-008: id_imm  input  32  sign-extended immediate.
REQ-009: id_rd  input  5  destination register index.
REQ-010: dmem_valid  output  1  data-memory request.
REQ-011: dmem_ready  input  1  memory accepts the request and returns dmem_rdata in the same cycle.
REQ-012: dmem_addr  output  32  word-aligned byte address; dmem_wstrb  output  4; dmem_wdata  output  32; dmem_rdata  input  32.
REQ-013: wb_en  output  1; wb_rd  output  5; wb_data  output  32: register-file write port.
REQ-014: redirect  output  1; redirect_pc  output  32: one-cycle fetch redirect to IF_ID.
REQ-015: exception  output  1  sticky fault flag.

Function
REQ-016: FSM states: IDLE (accepting), MEM (waiting on dmem_ready), HALT (faulted); id_ready SHALL be 1 only in IDLE.
REQ-017: ALU/LUI/AUIPC op accepted in cycle N SHALL drive wb_en=1, wb_rd=id_rd, wb_data=result in cycle N+1 (registered outputs); 32-bit wraparound arithmetic; shift amount = operand[4:0]; SRA arithmetic.
REQ-018: Taken branch SHALL pulse redirect=1 in N+1 with redirect_pc=id_pc+id_imm; not-taken: redirect=0.
REQ-019: JAL: redirect_pc=id_pc+id_imm; JALR: redirect_pc=(rs1+imm)&~1; both write rd=id_pc+4.
REQ-020: Any write with rd=0 SHALL keep wb_en=0.
REQ-021: Load/store accepted in N SHALL enter MEM and assert dmem_valid from N+1, holding dmem_addr/wstrb/wdata stable until dmem_ready=1, then return to IDLE next cycle.
REQ-022: Load writeback SHALL occur the cycle after dmem_ready; byte/half selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-023: Stores: wstrb = 0001<<a (SB), 0011<<a (SH), 1111 (SW); wdata = byte/half replicated across lanes; loads use wstrb=0000.
REQ-024: Misaligned access (LH/SH a[0]=1, LW/SW a[1:0]!=0) or jump target with bit1=1 SHALL set exception in N+1, issue no memory request or writeback, and enter HALT.
REQ-025: HALT SHALL hold id_ready=0, all pulses 0, until reset.
REQ-026: Instruction presented in the cycle redirect=1 SHALL be discarded (not executed) even if id_valid=1.
REQ-027: Undefined id_op SHALL be treated as fault per REQ-024.

Reset
REQ-028: On resetb=0: state=IDLE, id_ready=0 during reset, dmem_valid=0, dmem_wstrb=0, wb_en=0, redirect=0, exception=0, data outputs 0; reset mid-MEM SHALL abandon the request immediately.

Structure
REQ-029: ex_wb_pkg SHALL hold op enumeration, FSM state type, and strobe/size constants.
REQ-030: Combinational sub-module ex_alu (operands, op -> result, branch-taken) SHALL be instantiated once.

Verification
REQ-031: ADD rs1=7, rs2=0xFFFFFFFF, rd=5 -> next cycle wb_en=1, wb_rd=5, wb_data=6.
REQ-032: BNE pc=0x100, rs1=1, rs2=2, imm=-8 -> redirect=1, redirect_pc=0xF8 for exactly one cycle; following id_valid instruction ignored.
REQ-033: LB addr=0x1003, dmem_rdata=0x80FFFFFF, dmem_ready delayed 3 cycles -> dmem_valid held 3 cycles stable, then wb_data=0xFFFFFF80; id_ready=0 throughout.
REQ-034: SH rs2=0x1234ABCD, addr=0x2002 -> dmem_wstrb=1100, dmem_wdata=0xABCDABCD.
REQ-035: LW addr=0x2001 -> exception=1, dmem_valid never asserted, id_ready stays 0 until resetb pulse.
REQ-036: resetb asserted while in MEM -> dmem_valid=0 immediately, state IDLE after release.

Source files
------------

// File: rtl/ex_wb_pkg.sv
// Shared types for the execute/writeback stage: opcodes, FSM states,
// byte-strobe and access-size constants, and the load lane extractor.
package ex_wb_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_SLL   = 5'd2,
        OP_SLT   = 5'd3,
        OP_SLTU  = 5'd4,
        OP_XOR   = 5'd5,
        OP_SRL   = 5'd6,
        OP_SRA   = 5'd7,
        OP_OR    = 5'd8,
        OP_AND   = 5'd9,
        OP_LUI   = 5'd10,
        OP_AUIPC = 5'd11,
        OP_BEQ   = 5'd12,
        OP_BNE   = 5'd13,
        OP_BLT   = 5'd14,
        OP_BGE   = 5'd15,
        OP_BLTU  = 5'd16,
        OP_BGEU  = 5'd17,
        OP_JAL   = 5'd18,
        OP_JALR  = 5'd19,
        OP_LB    = 5'd20,
        OP_LH    = 5'd21,
        OP_LW    = 5'd22,
        OP_LBU   = 5'd23,
        OP_LHU   = 5'd24,
        OP_SB    = 5'd25,
        OP_SH    = 5'd26,
        OP_SW    = 5'd27
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_H    = 4'b0011;
    localparam logic [3:0] STRB_W    = 4'b1111;

    // Pick the addressed byte/half out of the returned word and extend.
    function automatic logic [31:0] ld_extract(
        input op_t         op,
        input logic [1:0]  lane,
        input logic [31:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{lane, 3'b000} +: 8];
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'b0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'b0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_wb_if.sv
// Handshake bundles for the execute stage.
// ex_wb_id_if: decoded instruction from IF_ID (valid/ready).
// ex_wb_dmem_if: data-memory request with same-cycle read data.
interface ex_wb_id_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_op;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rd;

    modport master (
        output id_valid, id_pc, id_op,
        output id_rs1_data, id_rs2_data,
        output id_imm, id_rd,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_pc, id_op,
        input  id_rs1_data, id_rs2_data,
        input  id_imm, id_rd,
        output id_ready
    );
endinterface

interface ex_wb_dmem_if;
    logic        dmem_valid;
    logic        dmem_ready;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_valid, dmem_addr,
        output dmem_wstrb, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_valid, dmem_addr,
        input  dmem_wstrb, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/ex_alu.sv
// Combinational ALU: i_op, i_a/i_b (rs1/rs2), i_pc, i_imm
// -> o_result (ALU/LUI/AUIPC) and o_taken (branch compare).
module ex_alu
    import ex_wb_pkg::*;
(
    input  op_t         i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    output logic [31:0] o_result,
    output logic        o_taken
);

    logic w_lt;
    logic w_ltu;

    assign w_lt  = $signed(i_a) < $signed(i_b);
    assign w_ltu = i_a < i_b;

    always_comb begin
        o_result = '0;
        o_taken  = 1'b0;
        case (i_op)
            OP_ADD:   o_result = i_a + i_b;
            OP_SUB:   o_result = i_a - i_b;
            OP_SLL:   o_result = i_a << i_b[4:0];
            OP_SLT:   o_result = {31'b0, w_lt};
            OP_SLTU:  o_result = {31'b0, w_ltu};
            OP_XOR:   o_result = i_a ^ i_b;
            OP_SRL:   o_result = i_a >> i_b[4:0];
            OP_SRA:   o_result = $signed(i_a) >>> i_b[4:0];
            OP_OR:    o_result = i_a | i_b;
            OP_AND:   o_result = i_a & i_b;
            OP_LUI:   o_result = i_imm;
            OP_AUIPC: o_result = i_pc + i_imm;
            OP_BEQ:   o_taken  = i_a == i_b;
            OP_BNE:   o_taken  = i_a != i_b;
            OP_BLT:   o_taken  = w_lt;
            OP_BGE:   o_taken  = !w_lt;
            OP_BLTU:  o_taken  = w_ltu;
            OP_BGEU:  o_taken  = !w_ltu;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/ex_wb.sv
// Execute/writeback stage: ALU, branches, jumps, loads/stores, faults.
// Ports: clk, resetb, id (IF_ID slave), dmem (memory master),
// wb_en/wb_rd/wb_data, redirect/redirect_pc, exception.
module ex_wb
    import ex_wb_pkg::*;
(
    input  logic         clk,
    input  logic         resetb,
    ex_wb_id_if.slave    id,
    ex_wb_dmem_if.master dmem,
    output logic         wb_en,
    output logic [4:0]   wb_rd,
    output logic [31:0]  wb_data,
    output logic         redirect,
    output logic [31:0]  redirect_pc,
    output logic         exception
);

    state_t      r_state;
    logic        r_id_ready;
    logic        r_wb_en;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;
    logic        r_exception;
    logic        r_dmem_valid;
    logic [31:0] r_dmem_addr;
    logic [3:0]  r_dmem_wstrb;
    logic [31:0] r_dmem_wdata;
    logic        r_ld;
    op_t         r_ld_op;
    logic [1:0]  r_lane;
    logic [4:0]  r_ld_rd;

    op_t         w_op;
    logic [31:0] w_alu;
    logic        w_taken;
    logic        w_is_alu;
    logic        w_is_br;
    logic        w_is_jmp;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_bad_op;
    size_t       w_size;
    logic [31:0] w_addr;
    logic [31:0] w_br_tgt;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_link;
    logic        w_misal;
    logic        w_fault;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic        w_fire;
    logic        w_rd_nz;

    assign w_op = op_t'(id.id_op);

    ex_alu u_alu (
        .i_op     (w_op),
        .i_a      (id.id_rs1_data),
        .i_b      (id.id_rs2_data),
        .i_pc     (id.id_pc),
        .i_imm    (id.id_imm),
        .o_result (w_alu),
        .o_taken  (w_taken)
    );

    always_comb begin
        w_is_alu = 1'b0;
        w_is_br  = 1'b0;
        w_is_jmp = 1'b0;
        w_is_ld  = 1'b0;
        w_is_st  = 1'b0;
        w_bad_op = 1'b0;
        w_size   = SZ_W;
        case (w_op)
            OP_ADD, OP_SUB, OP_SLL, OP_SLT,
            OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
            OP_OR, OP_AND, OP_LUI, OP_AUIPC:
                w_is_alu = 1'b1;
            OP_BEQ, OP_BNE, OP_BLT,
            OP_BGE, OP_BLTU, OP_BGEU:
                w_is_br = 1'b1;
            OP_JAL, OP_JALR:
                w_is_jmp = 1'b1;
            OP_LB, OP_LBU: begin
                w_is_ld = 1'b1;
                w_size  = SZ_B;
            end
            OP_LH, OP_LHU: begin
                w_is_ld = 1'b1;
                w_size  = SZ_H;
            end
            OP_LW:
                w_is_ld = 1'b1;
            OP_SB: begin
                w_is_st = 1'b1;
                w_size  = SZ_B;
            end
            OP_SH: begin
                w_is_st = 1'b1;
                w_size  = SZ_H;
            end
            OP_SW:
                w_is_st = 1'b1;
            default:
                w_bad_op = 1'b1;
        endcase
    end

    assign w_addr   = id.id_rs1_data + id.id_imm;
    assign w_br_tgt = id.id_pc + id.id_imm;
    assign w_link   = id.id_pc + 32'd4;
    assign w_rd_nz  = id.id_rd != 5'd0;

    // JALR clears bit0; a set bit1 is still a misaligned target.
    assign w_jmp_tgt = (w_op == OP_JALR) ?
                       {w_addr[31:1], 1'b0} : w_br_tgt;

    assign w_misal = (w_is_ld | w_is_st) &
                     (((w_size == SZ_H) & w_addr[0]) |
                      ((w_size == SZ_W) & (w_addr[1:0] != 2'b00)));

    assign w_fault = w_bad_op | w_misal |
                     (w_is_jmp & w_jmp_tgt[1]);

    always_comb begin
        case (w_size)
            SZ_B: begin
                w_strb  = STRB_B << w_addr[1:0];
                w_wdata = {4{id.id_rs2_data[7:0]}};
            end
            SZ_H: begin
                w_strb  = STRB_H << w_addr[1:0];
                w_wdata = {2{id.id_rs2_data[15:0]}};
            end
            default: begin
                w_strb  = STRB_W;
                w_wdata = id.id_rs2_data;
            end
        endcase
    end

    // The slot right after a redirect is on the wrong path: drop it.
    assign w_fire = id.id_valid & r_id_ready & ~r_redirect;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state       <= ST_IDLE;
            r_id_ready    <= 1'b0;
            r_wb_en       <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_exception   <= 1'b0;
            r_dmem_valid  <= 1'b0;
            r_dmem_addr   <= '0;
            r_dmem_wstrb  <= STRB_NONE;
            r_dmem_wdata  <= '0;
            r_ld          <= 1'b0;
            r_ld_op       <= OP_LW;
            r_lane        <= '0;
            r_ld_rd       <= '0;
        end else begin
            r_wb_en    <= 1'b0;
            r_redirect <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_id_ready <= 1'b1;
                    if (w_fire) begin
                        if (w_fault) begin
                            r_exception <= 1'b1;
                            r_id_ready  <= 1'b0;
                            r_state     <= ST_HALT;
                        end else if (w_is_alu) begin
                            r_wb_en   <= w_rd_nz;
                            r_wb_rd   <= id.id_rd;
                            r_wb_data <= w_alu;
                        end else if (w_is_br) begin
                            r_redirect    <= w_taken;
                            r_redirect_pc <= w_br_tgt;
                        end else if (w_is_jmp) begin
                            r_redirect    <= 1'b1;
                            r_redirect_pc <= w_jmp_tgt;
                            r_wb_en       <= w_rd_nz;
                            r_wb_rd       <= id.id_rd;
                            r_wb_data     <= w_link;
                        end else begin
                            r_id_ready   <= 1'b0;
                            r_state      <= ST_MEM;
                            r_dmem_valid <= 1'b1;
                            r_dmem_addr  <= {w_addr[31:2], 2'b00};
                            r_dmem_wstrb <= w_is_st ?
                                            w_strb : STRB_NONE;
                            r_dmem_wdata <= w_is_st ?
                                            w_wdata : 32'd0;
                            r_ld         <= w_is_ld;
                            r_ld_op      <= w_op;
                            r_lane       <= w_addr[1:0];
                            r_ld_rd      <= id.id_rd;
                        end
                    end
                end
                ST_MEM: begin
                    if (dmem.dmem_ready) begin
                        r_dmem_valid <= 1'b0;
                        r_dmem_wstrb <= STRB_NONE;
                        r_id_ready   <= 1'b1;
                        r_state      <= ST_IDLE;
                        if (r_ld) begin
                            r_wb_en   <= r_ld_rd != 5'd0;
                            r_wb_rd   <= r_ld_rd;
                            r_wb_data <= ld_extract(
                                r_ld_op, r_lane,
                                dmem.dmem_rdata);
                        end
                    end
                end
                ST_HALT: begin
                    r_id_ready <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign id.id_ready       = r_id_ready;
    assign dmem.dmem_valid   = r_dmem_valid;
    assign dmem.dmem_addr    = r_dmem_addr;
    assign dmem.dmem_wstrb   = r_dmem_wstrb;
    assign dmem.dmem_wdata   = r_dmem_wdata;
    assign wb_en             = r_wb_en;
    assign wb_rd             = r_wb_rd;
    assign wb_data           = r_wb_data;
    assign redirect          = r_redirect;
    assign redirect_pc       = r_redirect_pc;
    assign exception         = r_exception;

endmodule

// File: tb/tb_ex_wb.sv
// Directed bench for ex_wb with a writeback scoreboard.
// Expected writebacks are queued at issue and popped on wb_en.
module tb_ex_wb;
    import ex_wb_pkg::*;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exception;

    ex_wb_id_if   id_bus ();
    ex_wb_dmem_if dm_bus ();

    ex_wb u_dut (
        .clk         (clk),
        .resetb      (resetb),
        .id          (id_bus.slave),
        .dmem        (dm_bus.master),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exception   (exception)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t sb[$];
    int  n_pass  = 0;
    int  n_total = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h",
                    tag, obs, exp);
    endtask

    task automatic expect_wb(input logic [4:0] rd,
                             input logic [31:0] data);
        wb_t e;
        e.rd   = rd;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic tick();
        wb_t e;
        @(posedge clk);
        #1;
        if (wb_en !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", {31'b0, wb_en}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                chk("wb_data", wb_data, e.data);
            end
        end
    endtask

    task automatic issue(input logic [4:0] op,
                         input logic [31:0] pc,
                         input logic [31:0] rs1,
                         input logic [31:0] rs2,
                         input logic [31:0] imm,
                         input logic [4:0] rd);
        id_bus.id_op       = op;
        id_bus.id_pc       = pc;
        id_bus.id_rs1_data = rs1;
        id_bus.id_rs2_data = rs2;
        id_bus.id_imm      = imm;
        id_bus.id_rd       = rd;
        id_bus.id_valid    = 1'b1;
        tick();
        id_bus.id_valid    = 1'b0;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        id_bus.id_valid = 1'b0;
        tick();
        resetb = 1'b1;
        tick();
    endtask

    initial begin
        id_bus.id_valid    = 1'b0;
        id_bus.id_op       = '0;
        id_bus.id_pc       = '0;
        id_bus.id_rs1_data = '0;
        id_bus.id_rs2_data = '0;
        id_bus.id_imm      = '0;
        id_bus.id_rd       = '0;
        dm_bus.dmem_ready  = 1'b0;
        dm_bus.dmem_rdata  = '0;

        repeat (2) tick();
        chk("rst_id_ready", {31'b0, id_bus.id_ready}, 0);
        chk("rst_dmem_valid", {31'b0, dm_bus.dmem_valid}, 0);
        chk("rst_wstrb", {28'b0, dm_bus.dmem_wstrb}, 0);
        chk("rst_wb_en", {31'b0, wb_en}, 0);
        chk("rst_redirect", {31'b0, redirect}, 0);
        chk("rst_exception", {31'b0, exception}, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        resetb = 1'b1;
        tick();
        chk("idle_id_ready", {31'b0, id_bus.id_ready}, 1);

        expect_wb(5, 32'd6);
        issue(OP_ADD, 0, 7, 32'hFFFF_FFFF, 0, 5);
        chk("add_wb_en", {31'b0, wb_en}, 1);
        expect_wb(1, 32'hFFFF_FFFE);
        issue(OP_SUB, 0, 3, 5, 0, 1);
        expect_wb(2, 32'hF800_0000);
        issue(OP_SRA, 0, 32'h8000_0000, 36, 0, 2);
        expect_wb(3, 32'h0800_0000);
        issue(OP_SRL, 0, 32'h8000_0000, 4, 0, 3);
        expect_wb(4, 32'd1);
        issue(OP_SLTU, 0, 1, 32'hFFFF_FFFF, 0, 4);
        expect_wb(6, 32'd1);
        issue(OP_SLT, 0, 32'hFFFF_FFFF, 1, 0, 6);
        expect_wb(7, 32'h1234_5000);
        issue(OP_LUI, 0, 0, 0, 32'h1234_5000, 7);
        expect_wb(8, 32'h0000_3000);
        issue(OP_AUIPC, 32'h1000, 0, 0, 32'h2000, 8);
        issue(OP_ADD, 0, 1, 1, 0, 0);
        chk("rd0_wb_en", {31'b0, wb_en}, 0);

        issue(OP_BNE, 32'h100, 1, 2, 32'hFFFF_FFF8, 0);
        chk("bne_redirect", {31'b0, redirect}, 1);
        chk("bne_target", redirect_pc, 32'h0000_00F8);
        id_bus.id_op       = OP_ADD;
        id_bus.id_rs1_data = 9;
        id_bus.id_rs2_data = 9;
        id_bus.id_rd       = 9;
        id_bus.id_valid    = 1'b1;
        tick();
        id_bus.id_valid = 1'b0;
        chk("bne_pulse_end", {31'b0, redirect}, 0);
        chk("flushed_wb_en", {31'b0, wb_en}, 0);
        issue(OP_BEQ, 32'h100, 1, 2, 32'h40, 0);
        chk("beq_nt_redirect", {31'b0, redirect}, 0);

        expect_wb(1, 32'h204);
        issue(OP_JAL, 32'h200, 0, 0, 32'h40, 1);
        chk("jal_redirect", {31'b0, redirect}, 1);
        chk("jal_target", redirect_pc, 32'h240);
        tick();
        expect_wb(2, 32'h404);
        issue(OP_JALR, 32'h400, 32'h301, 0, 32'h10, 2);
        chk("jalr_target", redirect_pc, 32'h310);
        tick();

        dm_bus.dmem_ready = 1'b0;
        dm_bus.dmem_rdata = 32'h80FF_FFFF;
        expect_wb(3, 32'hFFFF_FF80);
        issue(OP_LB, 0, 32'h1000, 0, 3, 3);
        for (int i = 0; i < 3; i++) begin
            chk("lb_valid", {31'b0, dm_bus.dmem_valid}, 1);
            chk("lb_addr", dm_bus.dmem_addr, 32'h1000);
            chk("lb_wstrb", {28'b0, dm_bus.dmem_wstrb}, 0);
            chk("lb_id_ready", {31'b0, id_bus.id_ready}, 0);
            if (i == 2) dm_bus.dmem_ready = 1'b1;
            tick();
        end
        chk("lb_wb_en", {31'b0, wb_en}, 1);
        chk("lb_valid_drop", {31'b0, dm_bus.dmem_valid}, 0);
        chk("lb_back_idle", {31'b0, id_bus.id_ready}, 1);

        issue(OP_SH, 0, 32'h2000, 32'h1234_ABCD, 2, 0);
        chk("sh_valid", {31'b0, dm_bus.dmem_valid}, 1);
        chk("sh_addr", dm_bus.dmem_addr, 32'h2000);
        chk("sh_wstrb", {28'b0, dm_bus.dmem_wstrb}, 32'hC);
        chk("sh_wdata", dm_bus.dmem_wdata, 32'hABCD_ABCD);
        tick();
        chk("sh_no_wb", {31'b0, wb_en}, 0);
        issue(OP_SB, 0, 32'h2001, 32'h55, 0, 0);
        chk("sb_wstrb", {28'b0, dm_bus.dmem_wstrb}, 32'h2);
        chk("sb_wdata", dm_bus.dmem_wdata, 32'h5555_5555);
        tick();
        issue(OP_SW, 0, 32'h2004, 32'hCAFE_F00D, 0, 0);
        chk("sw_wstrb", {28'b0, dm_bus.dmem_wstrb}, 32'hF);
        chk("sw_wdata", dm_bus.dmem_wdata, 32'hCAFE_F00D);
        tick();

        dm_bus.dmem_rdata = 32'h8001_7FFF;
        expect_wb(6, 32'h0000_8001);
        issue(OP_LHU, 0, 32'h2000, 0, 2, 6);
        tick();
        expect_wb(7, 32'hFFFF_8001);
        issue(OP_LH, 0, 32'h2000, 0, 2, 7);
        tick();
        expect_wb(8, 32'h0000_007F);
        issue(OP_LBU, 0, 32'h2001, 0, 0, 8);
        tick();

        issue(OP_LW, 0, 32'h2000, 0, 1, 9);
        chk("lw_mis_exc", {31'b0, exception}, 1);
        chk("lw_mis_valid", {31'b0, dm_bus.dmem_valid}, 0);
        chk("lw_mis_ready", {31'b0, id_bus.id_ready}, 0);
        id_bus.id_op    = OP_ADD;
        id_bus.id_rd    = 10;
        id_bus.id_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_ready", {31'b0, id_bus.id_ready}, 0);
            chk("halt_valid", {31'b0, dm_bus.dmem_valid}, 0);
            chk("halt_exc", {31'b0, exception}, 1);
        end
        id_bus.id_valid = 1'b0;
        resetb = 1'b0;
        #1;
        chk("halt_rst_exc", {31'b0, exception}, 0);
        do_reset();
        chk("halt_rst_ready", {31'b0, id_bus.id_ready}, 1);

        issue(5'd31, 0, 0, 0, 0, 1);
        chk("badop_exc", {31'b0, exception}, 1);
        chk("badop_wb", {31'b0, wb_en}, 0);
        do_reset();

        issue(OP_JAL, 32'h100, 0, 0, 2, 1);
        chk("jal_mis_exc", {31'b0, exception}, 1);
        chk("jal_mis_redir", {31'b0, redirect}, 0);
        do_reset();

        dm_bus.dmem_ready = 1'b0;
        issue(OP_LW, 0, 32'h3000, 0, 0, 4);
        tick();
        chk("mem_rst_pre", {31'b0, dm_bus.dmem_valid}, 1);
        resetb = 1'b0;
        #1;
        chk("mem_rst_valid", {31'b0, dm_bus.dmem_valid}, 0);
        chk("mem_rst_wstrb", {28'b0, dm_bus.dmem_wstrb}, 0);
        chk("mem_rst_ready", {31'b0, id_bus.id_ready}, 0);
        do_reset();
        chk("mem_rst_idle", {31'b0, id_bus.id_ready}, 1);
        chk("mem_rst_nvalid", {31'b0, dm_bus.dmem_valid}, 0);
        dm_bus.dmem_ready = 1'b1;
        expect_wb(11, 32'd30);
        issue(OP_ADD, 0, 10, 20, 0, 11);
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
